// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer: DEPTH-entry circular FIFO with valid/ready on both sides,
// flush-to-bubble, occupancy output and a saturating stall-cycle counter.
module pipe_stage_buf #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_W-1:0]           stall_cycles
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = $clog2(DEPTH + 1);
    localparam logic [OccW-1:0] Full = OccW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]  count_q, count_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             push, pop;

    // Handshake outputs come straight from registered occupancy; no out_ready -> in_ready path.
    assign in_ready  = (count_q != Full);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign out_data     = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign stall_cycles = stall_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + OccW'(1);
                2'b01:   count_d = count_q - OccW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Flush does not clear the stall counter; only reset does.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // Popped and flushed slots are zeroed so an empty head always reads as a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= in_data;
            if (pop)  mem_q[rd_ptr_q] <= '0;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a queue-based reference model tracks accepted payloads,
// a negedge monitor compares every output and pops on each downstream handshake.
module tb_pipe_stage_buf;
    localparam int unsigned WIDTH     = 64;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned OCC_W     = $clog2(DEPTH + 1);
    localparam int unsigned STALL_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] count;
    logic [CNT_W-1:0] stall_cycles;

    int               checks = 0;
    int               failures = 0;
    logic [WIDTH-1:0] exp_q[$];
    int               model_cnt = 0;
    int               stall_m = 0;
    bit               m_push, m_pop;

    pipe_stage_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: occupancy, accepted payload queue and saturating stall counter.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            exp_q.delete();
            model_cnt = 0;
            stall_m   = 0;
        end else begin
            m_push = in_valid && (model_cnt < DEPTH) && !flush;
            m_pop  = (model_cnt > 0) && out_ready && !flush;
            if ((model_cnt > 0) && !out_ready && (stall_m < STALL_MAX)) stall_m++;
            if (flush) begin
                exp_q.delete();
                model_cnt = 0;
            end else begin
                if (m_push) exp_q.push_back(in_data);
                model_cnt = model_cnt + int'(m_push) - int'(m_pop);
            end
        end
    end

    // Monitor: compares outputs before each edge and retires the head on a DUT handshake.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk("count", WIDTH'(count), WIDTH'(model_cnt));
            chk("in_ready", WIDTH'(in_ready), WIDTH'(model_cnt < DEPTH));
            chk("out_valid", WIDTH'(out_valid), WIDTH'(model_cnt != 0));
            chk("stall_cycles", WIDTH'(stall_cycles), WIDTH'(stall_m));
            if (exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
            else                  chk("out_data_bubble", out_data, '0);
            if (out_valid && out_ready && !flush && (exp_q.size() > 0)) void'(exp_q.pop_front());
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Offer one payload and hold it until accepted (bounded).
    task automatic send(input logic [WIDTH-1:0] d);
        int n = 0;
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            acc = in_ready;
            cycle();
            n++;
        end while (!acc && n < 50);
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL send_timeout: payload 0x%0h not accepted within %0d cycles", d, n);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"}, WIDTH'(count), '0);
        chk({tag, "_out_valid"}, WIDTH'(out_valid), '0);
        chk({tag, "_out_data"}, out_data, '0);
        chk({tag, "_in_ready"}, WIDTH'(in_ready), WIDTH'(1));
        chk({tag, "_stall"}, WIDTH'(stall_cycles), '0);
    endtask

    initial begin
        logic [WIDTH-1:0] stream[4];
        stream = '{64'h11, 64'h22, 64'h33, 64'h44};

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        reset = 1'b0;

        // Streaming with downstream always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = stream[i];
            cycle();
        end
        in_valid = 1'b0;
        repeat (3) cycle();

        // Backpressure: fill to DEPTH, hold a blocked offer, then release.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(64'hA0 + 64'(i));
        in_valid = 1'b1;
        in_data  = 64'hA4;
        repeat (3) cycle();
        @(negedge clk);
        chk("full_in_ready", WIDTH'(in_ready), '0);
        cycle();
        out_ready = 1'b1;
        send(64'hA4);
        send(64'hA5);
        repeat (6) cycle();

        // Asynchronous reset mid-traffic with two entries held.
        out_ready = 1'b0;
        send(64'h1);
        send(64'h2);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        cycle();
        reset = 1'b0;

        // Flush colliding with a push and a pop in the same cycle.
        for (int i = 0; i < 3; i++) send(64'hC0 + 64'(i));
        in_valid  = 1'b1;
        in_data   = 64'hDEAD;
        out_ready = 1'b1;
        flush     = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", WIDTH'(count), '0);
        chk("flush_out_valid", WIDTH'(out_valid), '0);
        chk("flush_out_data", out_data, '0);
        repeat (4) cycle();

        // Stall counter saturation.
        reset = 1'b1;
        cycle();
        reset     = 1'b0;
        out_ready = 1'b0;
        send(64'h5A);
        repeat (20) cycle();
        chk("stall_saturated", WIDTH'(stall_cycles), WIDTH'(STALL_MAX));
        out_ready = 1'b1;
        repeat (3) cycle();

        // Random traffic with varying occupancy, pointer wrap and occasional flush.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
            cycle();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (8) cycle();
        chk("final_count", WIDTH'(count), '0);
        chk("all_delivered", WIDTH'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline-stage buffer placed between two pipeline stages, such as decode→execute or execute→memory. It generalises a fixed stage register with flush and stall into a DEPTH-entry circular buffer with a valid/ready handshake on both sides. It also provides a flush that squashes every held entry, an occupancy output, and a saturating stall-cycle performance counter. Emptied slots present all-zero payload, which is a bubble, so downstream stages see the same "zero = no-op" convention as a flushed stage register.

## Interface
Parameters:
- WIDTH, 64, payload bits per entry (≥1)
- DEPTH, 2, number of entries; legal values 2, 4, 8, 16 (power of two, ≥2)
- CNT_W, 32, width of the stall-cycle counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  squash all entries at the next edge; highest priority
- in_valid  in  1  upstream offers in_data
- in_ready  out  1  buffer can accept; equals (count < DEPTH), depends only on registered state
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  head entry present; equals (count != 0)
- out_ready  in  1  downstream accepts head
- out_data  out  WIDTH  head payload; all-zero when out_valid=0
- count  out  $clog2(DEPTH+1)  current occupancy
- stall_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Storage: DEPTH×WIDTH array, write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping naturally modulo DEPTH.
- push = in_valid & in_ready & !flush. On a push: mem[wr_ptr] ← in_data, then wr_ptr++.
- pop = out_valid & out_ready & !flush. On a pop: mem[rd_ptr] ← 0, then rd_ptr++.
- Next count:
  - count + push − pop.
  - push and pop together leave count unchanged.
  - When full, in_ready=0, so there is no simultaneous push with pop-to-free-slot. There is no same-cycle bypass in either direction.
- Flush at an edge:
  - count←0, wr_ptr←0, rd_ptr←0, all mem entries←0.
  - Any in_valid/out_ready handshake in that cycle is ignored. The upstream transfer is lost and the downstream did not consume anything.
- stall_cycles: increments by 1 on each edge where out_valid & !out_ready.
  - Saturates at 2^CNT_W−1.
  - Not cleared by flush; cleared only by reset.
- out_data = mem[rd_ptr]. Zeroing on pop and flush guarantees zero whenever count=0.
- Ordering: strict FIFO; every pushed payload is output exactly once unless flushed.
- Reset values: count=0, in_ready=1, out_valid=0, out_data=0, stall_cycles=0, pointers 0, mem all 0.

## Timing
- Latency: payload pushed at edge N is presented on out_data/out_valid after edge N, i.e. it is poppable at edge N+1. Minimum latency is 1 cycle; there is no combinational in→out path.
- Throughput: 1 transfer/cycle sustained when DEPTH≥2 and the downstream always accepts.
- in_ready, out_valid, out_data and count are all pure functions of registers. There is no combinational path from out_ready to in_ready.
- Full (count=DEPTH): in_ready=0 for that whole cycle, even if a pop occurs. It rises after the pop edge.
- Empty (count=0): out_valid=0; out_ready is ignored; stall_cycles does not increment.
- Wrap-around: the pointers wrap from DEPTH−1 to 0 with no bubble. count distinguishes full from empty.
- Flush together with push/pop at the same edge: flush wins, and the result is empty.
- reset asserted mid-operation: all outputs go to their reset values asynchronously, without waiting for clk. Deassertion is synchronised externally.

## Test plan
- Reset/idle, DEPTH=2, WIDTH=64: assert reset mid-traffic with count=2. Required immediately: count=0, out_valid=0, out_data=0, in_ready=1, stall_cycles=0.
- Streaming, DEPTH=2: push 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=1. Required: out_data is 0x11..0x44 on four consecutive cycles starting one cycle after the first push; in_ready stays 1; count stays ≤1.
- Backpressure and fill, DEPTH=4, out_ready=0: push 0xA0..0xA5.
  - Required: 0xA0..0xA3 accepted; in_ready=0 once count=4; stall_cycles increments each cycle from the first valid.
  - Then out_ready=1: 0xA4 and 0xA5 are accepted and drained in order. The total output sequence is 0xA0..0xA5.
- Wrap-around, DEPTH=4: 10 push/pop cycles at varying occupancy (1..3). Required: output order matches input order across pointer wrap; no duplicates or drops.
- Flush with simultaneous handshake: count=3, in_valid=1, out_ready=1 and flush=1 in the same cycle. Required after the edge: count=0, out_valid=0, out_data=0; the in_data of that cycle is never output; stall_cycles is unchanged.
- Counter saturation, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles. Required: stall_cycles reaches 15 and holds at 15.
